// File: rtl/flopenr.sv
// rtl/flopenr.sv - parameterised register with synchronous active-high reset and load enable
module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset is tested first so an unknown en cannot leak into q while reset is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_flopenr.sv
// tb/tb_flopenr.sv - directed self-checking bench for flopenr at widths 32, 1 and 5
module tb_flopenr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset32, en32;
    logic [31:0] d32, q32;
    logic        reset1, en1;
    logic [0:0]  d1, q1;
    logic        reset5, en5;
    logic [4:0]  d5, q5;

    int checks   = 0;
    int failures = 0;

    flopenr #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .en(en32), .d(d32), .q(q32));
    flopenr #(.WIDTH(1))  dut1  (.clk(clk), .reset(reset1),  .en(en1),  .d(d1),  .q(q1));
    flopenr #(.WIDTH(5))  dut5  (.clk(clk), .reset(reset5),  .en(en5),  .d(d5),  .q(q5));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vals [10];

    initial begin
        reset32 = 1'b1; en32 = 1'b1; d32 = 32'hDEAD_BEEF;
        reset1  = 1'b1; en1  = 1'b1; d1  = 1'b1;
        reset5  = 1'b1; en5  = 1'b1; d5  = 5'h1F;
        #1;
        tick();
        check("reset32_first", q32, 32'h0);
        check("reset1_first", {31'b0, q1}, 32'h0);
        check("reset5_first", {27'b0, q5}, 32'h0);

        for (int i = 0; i < 3; i++) begin
            d32 = $urandom();
            tick();
            check("reset32_hold", q32, 32'h0);
        end

        // Release with en=1 loads d on the first edge
        reset32 = 1'b0; en32 = 1'b1; d32 = 32'h0000_0001;
        tick();
        check("release32_en", q32, 32'h1);

        d32 = 32'h1234_5678;
        tick();
        check("load32_a", q32, 32'h1234_5678);
        d32 = 32'hFFFF_FFFF;
        tick();
        check("load32_ones", q32, 32'hFFFF_FFFF);

        for (int i = 0; i < 10; i++) vals[i] = $urandom();
        for (int i = 0; i < 10; i++) begin
            d32 = vals[i];
            tick();
            check("load32_rand", q32, vals[i]);
        end

        d32 = 32'hA5A5_A5A5;
        tick();
        check("hold32_load", q32, 32'hA5A5_A5A5);
        en32 = 1'b0; d32 = 32'h5A5A_5A5A;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold32", q32, 32'hA5A5_A5A5);
        end

        d32 = 32'bx;
        tick();
        check("hold32_dx", q32, 32'hA5A5_A5A5);

        en32 = 1'b1; d32 = 32'hCAFE_F00D;
        tick();
        check("prio32_load", q32, 32'hCAFE_F00D);
        reset32 = 1'b1; en32 = 1'b1; d32 = 32'h1111_1111;
        #3;
        check("prio32_midcycle", q32, 32'hCAFE_F00D);
        tick();
        check("prio32_reset", q32, 32'h0);

        reset32 = 1'b0; en32 = 1'b1; d32 = 32'h7777_7777;
        tick();
        check("reload32", q32, 32'h7777_7777);
        reset32 = 1'b1; en32 = 1'bx;
        tick();
        check("reset32_enx", q32, 32'h0);

        reset32 = 1'b0; en32 = 1'b0; d32 = 32'h0BAD_CAFE;
        tick();
        check("release32_noen", q32, 32'h0);
        tick();
        check("release32_noen2", q32, 32'h0);

        // 1-bit instance
        reset1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
        tick();
        check("load1_one", {31'b0, q1}, 32'h1);
        en1 = 1'b0; d1 = 1'b0;
        tick();
        check("hold1", {31'b0, q1}, 32'h1);
        tick();
        check("hold1_b", {31'b0, q1}, 32'h1);
        reset1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
        tick();
        check("reset1_prio", {31'b0, q1}, 32'h0);
        reset1 = 1'b0; en1 = 1'b1; d1 = 1'b0;
        tick();
        check("load1_zero", {31'b0, q1}, 32'h0);

        // 5-bit instance
        reset5 = 1'b0; en5 = 1'b1; d5 = 5'h1F;
        tick();
        check("load5_ones", {27'b0, q5}, 32'h1F);
        d5 = 5'h0A;
        tick();
        check("load5_0a", {27'b0, q5}, 32'h0A);
        en5 = 1'b0; d5 = 5'h15;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold5", {27'b0, q5}, 32'h0A);
        end
        reset5 = 1'b1; en5 = 1'b1; d5 = 5'h1F;
        #3;
        check("prio5_midcycle", {27'b0, q5}, 32'h0A);
        tick();
        check("reset5_prio", {27'b0, q5}, 32'h0);
        reset5 = 1'b0; en5 = 1'b0;
        tick();
        check("release5_noen", {27'b0, q5}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
